// File: rtl/bus_master_port.sv
// Master-side bus initiator: takes one core command, arbitrates for the bus,
// serialises address/write data or collects read data, then answers the core.
module bus_master_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [1:0]            cmd_slave,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  m_request,
    output logic [1:0]            m_slave_sel,
    input  logic                  m_grant,
    output logic                  bus_valid,
    output logic                  bus_mode,
    output logic                  bus_wdata,
    input  logic                  bus_rdata,
    input  logic                  slave_ready
);

    localparam int SW   = ADDR_WIDTH + DATA_WIDTH;
    localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int BW   = $clog2(MAXW + 1);

    localparam logic [BW-1:0] ADDR_LAST = BW'(ADDR_WIDTH - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [7:0]    TO_LAST   = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, REQ, ADDR, WDATA, ACKWAIT, RWAIT, RDATA, DONE
    } state_t;

    state_t                  state_q,       state_d;
    logic [7:0]              cnt_q,         cnt_d;
    logic [BW-1:0]           bit_cnt_q,     bit_cnt_d;
    logic [SW-1:0]           sh_q,          sh_d;
    logic                    cmd_ready_q,   cmd_ready_d;
    logic                    rsp_valid_q,   rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q,   rsp_rdata_d;
    logic                    rsp_error_q,   rsp_error_d;
    logic                    m_request_q,   m_request_d;
    logic [1:0]              m_slave_sel_q, m_slave_sel_d;
    logic                    bus_valid_q,   bus_valid_d;
    logic                    bus_mode_q,    bus_mode_d;
    logic                    bus_wdata_q,   bus_wdata_d;

    logic                    finish;
    logic                    finish_err;
    logic [DATA_WIDTH-1:0]   rd_word;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_cnt_d     = bit_cnt_q;
        sh_d          = sh_q;
        cmd_ready_d   = cmd_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_error_d   = rsp_error_q;
        m_request_d   = m_request_q;
        m_slave_sel_d = m_slave_sel_q;
        bus_valid_d   = bus_valid_q;
        bus_mode_d    = bus_mode_q;
        bus_wdata_d   = bus_wdata_q;
        finish        = 1'b0;
        finish_err    = 1'b0;
        rd_word       = '0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d       = REQ;
                    cmd_ready_d   = 1'b0;
                    m_request_d   = 1'b1;
                    m_slave_sel_d = cmd_slave;
                    bus_mode_d    = cmd_write;
                    sh_d          = {cmd_addr, cmd_wdata};
                    cnt_d         = '0;
                end
            end

            REQ: begin
                if (m_grant) begin
                    state_d     = ADDR;
                    bus_valid_d = 1'b1;
                    bus_wdata_d = sh_q[SW-1];
                    sh_d        = {sh_q[SW-2:0], 1'b0};
                    bit_cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            // Address and write data sit back to back in sh_q, so the first
            // data bit is already at the top when the address phase ends.
            ADDR: begin
                if (!m_grant) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else if (bit_cnt_q == ADDR_LAST) begin
                    if (bus_mode_q) begin
                        state_d     = WDATA;
                        bus_wdata_d = sh_q[SW-1];
                        sh_d        = {sh_q[SW-2:0], 1'b0};
                        bit_cnt_d   = '0;
                    end else begin
                        state_d     = RWAIT;
                        bus_valid_d = 1'b0;
                        bus_wdata_d = 1'b0;
                        cnt_d       = '0;
                    end
                end else begin
                    bit_cnt_d   = bit_cnt_q + 1'b1;
                    bus_wdata_d = sh_q[SW-1];
                    sh_d        = {sh_q[SW-2:0], 1'b0};
                end
            end

            WDATA: begin
                if (!m_grant) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else if (bit_cnt_q == DATA_LAST) begin
                    state_d     = ACKWAIT;
                    bus_valid_d = 1'b0;
                    bus_wdata_d = 1'b0;
                    cnt_d       = '0;
                end else begin
                    bit_cnt_d   = bit_cnt_q + 1'b1;
                    bus_wdata_d = sh_q[SW-1];
                    sh_d        = {sh_q[SW-2:0], 1'b0};
                end
            end

            ACKWAIT: begin
                if (!m_grant) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else if (slave_ready) begin
                    finish = 1'b1;
                end else if (cnt_q == TO_LAST) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            RWAIT: begin
                if (!m_grant) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else if (slave_ready) begin
                    state_d   = RDATA;
                    bit_cnt_d = '0;
                end else if (cnt_q == TO_LAST) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            // The now idle address shifter doubles as the read deserialiser.
            RDATA: begin
                if (!m_grant) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else begin
                    sh_d = {sh_q[SW-2:0], bus_rdata};
                    if (bit_cnt_q == DATA_LAST) begin
                        finish  = 1'b1;
                        rd_word = {sh_q[DATA_WIDTH-2:0], bus_rdata};
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end

            DONE: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                rsp_error_d = 1'b0;
                rsp_rdata_d = '0;
            end

            default: state_d = IDLE;
        endcase

        if (finish) begin
            state_d       = DONE;
            rsp_valid_d   = 1'b1;
            rsp_error_d   = finish_err;
            rsp_rdata_d   = finish_err ? '0 : rd_word;
            m_request_d   = 1'b0;
            m_slave_sel_d = 2'b00;
            bus_valid_d   = 1'b0;
            bus_wdata_d   = 1'b0;
            bus_mode_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bit_cnt_q     <= '0;
            sh_q          <= '0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
            m_request_q   <= 1'b0;
            m_slave_sel_q <= 2'b00;
            bus_valid_q   <= 1'b0;
            bus_mode_q    <= 1'b0;
            bus_wdata_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            sh_q          <= sh_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_error_q   <= rsp_error_d;
            m_request_q   <= m_request_d;
            m_slave_sel_q <= m_slave_sel_d;
            bus_valid_q   <= bus_valid_d;
            bus_mode_q    <= bus_mode_d;
            bus_wdata_q   <= bus_wdata_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_error   = rsp_error_q;
    assign m_request   = m_request_q;
    assign m_slave_sel = m_slave_sel_q;
    assign bus_valid   = bus_valid_q;
    assign bus_mode    = bus_mode_q;
    assign bus_wdata   = bus_wdata_q;

endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: each transaction's cycle schedule is derived from
// grant/ready delays and the phase lengths, then every cycle is compared.
module tb_bus_master_port;

    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [1:0]    cmd_slave;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic          m_request;
    logic [1:0]    m_slave_sel;
    logic          m_grant;
    logic          bus_valid;
    logic          bus_mode;
    logic          bus_wdata;
    logic          bus_rdata;
    logic          slave_ready;

    bus_master_port #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (255)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_slave   (cmd_slave),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error),
        .m_request   (m_request),
        .m_slave_sel (m_slave_sel),
        .m_grant     (m_grant),
        .bus_valid   (bus_valid),
        .bus_mode    (bus_mode),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .slave_ready (slave_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // g: REQ cycles with grant low; r: wait cycles with slave_ready low;
    // drop: absolute cycle from which grant is pulled (-1 = never);
    // busy: pulse a stray command during the address phase.
    task automatic txn(input logic wr, input logic [1:0] sl, input logic [AW-1:0] ad,
                       input logic [DW-1:0] wd, input logic [DW-1:0] rw,
                       input int g, input int r, input int drop, input bit busy);
        int   a0, w0, rd0, done_c, nbits, idx;
        bit   err;
        logic exp_bv, exp_bit;
        a0     = 2 + g;
        w0     = 1 << 20;
        rd0    = 1 << 20;
        nbits  = wr ? AW + DW : AW;
        if (g >= 255) begin
            done_c = 256;
            err    = 1'b1;
        end else begin
            w0 = a0 + nbits;
            if (r >= 255) begin
                done_c = w0 + 255;
                err    = 1'b1;
            end else begin
                rd0    = w0 + r + 1;
                done_c = wr ? w0 + r + 1 : rd0 + DW;
                err    = 1'b0;
            end
            if (drop >= a0 && drop < done_c) begin
                done_c = drop + 1;
                err    = 1'b1;
            end
        end

        @(posedge clk); #1; cyc++;
        for (int c = 0; c <= done_c; c++) begin
            if (c > 0) begin
                @(posedge clk); #1; cyc++;
                exp_bv = (c < done_c) && (c >= a0) && (c < a0 + nbits);
                check("cmd_ready", 32'(cmd_ready), 32'(1'b0));
                check("m_request", 32'(m_request), 32'(c < done_c));
                check("rsp_valid", 32'(rsp_valid), 32'(c == done_c));
                check("bus_valid", 32'(bus_valid), 32'(exp_bv));
                if (c < done_c) begin
                    check("m_slave_sel", 32'(m_slave_sel), 32'(sl));
                    check("bus_mode", 32'(bus_mode), 32'(wr));
                end
                if (exp_bv) begin
                    idx     = c - a0;
                    exp_bit = (idx < AW) ? ad[AW-1-idx] : wd[DW-1-(idx-AW)];
                    check("bus_wdata", 32'(bus_wdata), 32'(exp_bit));
                end
                if (c == done_c) begin
                    check("rsp_error", 32'(rsp_error), 32'(err));
                    check("rsp_rdata", 32'(rsp_rdata), (!wr && !err) ? 32'(rw) : 32'd0);
                end
            end else begin
                check("idle_ready", 32'(cmd_ready), 32'd1);
                check("idle_request", 32'(m_request), 32'd0);
                check("idle_rsp", 32'(rsp_valid), 32'd0);
            end

            if (c == 0) begin
                cmd_valid = 1'b1;
                cmd_write = wr;
                cmd_slave = sl;
                cmd_addr  = ad;
                cmd_wdata = wd;
            end else if (busy && c == a0 + 3 && c < done_c) begin
                cmd_valid = 1'b1;
                cmd_write = 1'($urandom_range(0, 1));
                cmd_slave = 2'($urandom);
                cmd_addr  = AW'($urandom);
                cmd_wdata = DW'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            m_grant     = (g < 255) && (c >= 1 + g) && !(drop >= 0 && c >= drop);
            slave_ready = (c < w0) ? 1'($urandom_range(0, 1)) : (c >= w0 + r);
            bus_rdata   = (!wr && c >= rd0 && c < rd0 + DW) ? rw[DW-1-(c-rd0)]
                                                            : 1'($urandom_range(0, 1));
        end
    endtask

    task automatic reset_mid_addr();
        @(posedge clk); #1; cyc++;
        check("pre_idle_ready", 32'(cmd_ready), 32'd1);
        cmd_valid   = 1'b1;
        cmd_write   = 1'b1;
        cmd_slave   = 2'b11;
        cmd_addr    = 12'hFFF;
        cmd_wdata   = 8'hFF;
        m_grant     = 1'b1;
        slave_ready = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1; cyc++;
            cmd_valid = 1'b0;
        end
        check("pre_rst_bus_valid", 32'(bus_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_m_request", 32'(m_request), 32'd0);
        check("rst_m_slave_sel", 32'(m_slave_sel), 32'd0);
        check("rst_bus_valid", 32'(bus_valid), 32'd0);
        check("rst_bus_mode", 32'(bus_mode), 32'd0);
        check("rst_bus_wdata", 32'(bus_wdata), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_error", 32'(rsp_error), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        #2 rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1; cyc++;
            check("post_rst_rsp", 32'(rsp_valid), 32'd0);
            check("post_rst_req", 32'(m_request), 32'd0);
            check("post_rst_ready", 32'(cmd_ready), 32'd1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1);
    end

    initial begin
        logic        wr_r;
        int          g_r, r_r, drop_r;
        bit          busy_r;

        rst         = 1'b0;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_slave   = 2'b00;
        cmd_addr    = '0;
        cmd_wdata   = '0;
        m_grant     = 1'b0;
        bus_rdata   = 1'b0;
        slave_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_m_request", 32'(m_request), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_bus_valid", 32'(bus_valid), 32'd0);
        check("reset_slave_sel", 32'(m_slave_sel), 32'd0);
        rst = 1'b1;

        txn(1'b1, 2'b10, 12'hA5C, 8'h3C, 8'h00, 0, 0, -1, 1'b0);
        txn(1'b0, 2'b01, 12'h3F0, 8'h00, 8'hC3, 5, 3, -1, 1'b0);
        txn(1'b1, 2'b11, 12'h123, 8'h5A, 8'h00, 255, 0, -1, 1'b0);
        txn(1'b0, 2'b10, 12'h456, 8'h00, 8'h81, 254, 0, -1, 1'b0);
        txn(1'b1, 2'b01, 12'h789, 8'hE7, 8'h00, 0, 0, 2 + AW + 3, 1'b0);
        txn(1'b1, 2'b00, 12'hABC, 8'h99, 8'h00, 0, 255, -1, 1'b0);
        txn(1'b1, 2'b10, 12'h0F0, 8'hA5, 8'h00, 1, 2, -1, 1'b1);
        txn(1'b0, 2'b11, 12'hF0F, 8'h00, 8'h5A, 0, 1, -1, 1'b0);
        reset_mid_addr();

        for (int i = 0; i < 20; i++) begin
            wr_r   = 1'($urandom_range(0, 1));
            g_r    = $urandom_range(0, 6);
            r_r    = $urandom_range(0, 6);
            drop_r = ($urandom_range(0, 3) == 0) ? 2 + g_r + int'($urandom_range(0, 25)) : -1;
            busy_r = ($urandom_range(0, 3) == 0);
            txn(wr_r, 2'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
                g_r, r_r, drop_r, busy_r);
        end

        cmd_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1; cyc++;
            check("tail_ready", 32'(cmd_ready), 32'd1);
            check("tail_request", 32'(m_request), 32'd0);
            check("tail_rsp", 32'(rsp_valid), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
